// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO multiply/divide sequencing controller with D-stage stall
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic        is_signed_div;
  logic [31:0] dvd, dvs, dvs_safe, q_u, r_u, quot, rem;

  // Arithmetic on the latched operands; only sampled when the busy period ends
  always_comb begin
    prod_u        = {32'b0, a_q} * {32'b0, b_q};
    prod_s        = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    is_signed_div = (op_q == OP_DIV);
    dvd           = (is_signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
    dvs           = (is_signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
    // Divide-by-zero never commits, the guard only keeps the divider defined
    dvs_safe      = (dvs == 32'd0) ? 32'd1 : dvs;
    q_u           = dvd / dvs_safe;
    r_u           = dvd % dvs_safe;
    quot          = (is_signed_div && (a_q[31] ^ b_q[31])) ? (~q_u + 32'd1) : q_u;
    rem           = (is_signed_div && a_q[31]) ? (~r_u + 32'd1) : r_u;
  end

  // Stall any HI/LO instruction in D while the unit is occupied or being issued to
  always_comb begin
    stall = d_is_md & (busy_q | (start & ~op[2]));
  end

  // Next-state: issue in IDLE, count down in RUN, commit on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!op_q[1]) begin
            hi_d = (op_q == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
            lo_d = (op_q == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over every input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl
module tb_md_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  int total = 0;
  int bad = 0;
  int cnt;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a start for one cycle, then scramble the operand inputs
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'b111; a = 32'hA5A5_5A5A; b = 32'h0BAD_F00D;
  endtask

  // Expect n busy cycles then a single done cycle
  task automatic wait_done(input string tag, input int n);
    cnt = 0;
    for (int i = 0; i < n + 4 && busy === 1'b1; i++) begin
      if (done !== 1'b0) cnt = cnt + 100;
      cnt++;
      tick();
    end
    chk({tag, "_busy_cycles"}, cnt, n);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; d_is_md = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;

    // mult -2*3 with D-stage HI/LO instruction held, and a start during busy
    d_is_md = 1'b1;
    start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFE; b = 32'd3;
    #1;
    chk("issue_stall", {31'b0, stall}, 1);
    tick();
    start = 1'b0; a = 32'h1; b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", {31'b0, busy}, 1);
      chk("mult_stall", {31'b0, stall}, 1);
      chk("mult_nodone", {31'b0, done}, 0);
      start = (i == 2); op = 3'b000; a = 32'd5; b = 32'd5;
      tick();
      start = 1'b0;
    end
    chk("mult_done", {31'b0, done}, 1);
    chk("done_busy", {31'b0, busy}, 0);
    chk("done_stall", {31'b0, stall}, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    d_is_md = 1'b0;
    tick();
    chk("done_pulse_end", {31'b0, done}, 0);
    chk("mult_idle", {31'b0, busy}, 0);
    chk("mult_hi_hold", hi, 32'hFFFF_FFFF);

    // multu with all-ones operands
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    tick();

    // divu 100/7
    issue(3'b011, 32'd100, 32'd7);
    wait_done("divu", 10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    tick();

    // div -7/2
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    tick();

    // mthi then mtlo on consecutive cycles
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 0);
    op = 3'b101; a = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_busy", {31'b0, busy}, 0);
    chk("mtlo_done", {31'b0, done}, 0);

    // reserved op is ignored
    issue(3'b110, 32'hDEAD_BEEF, 32'd1);
    chk("rsv_busy", {31'b0, busy}, 0);
    chk("rsv_hi", hi, 32'h1234_5678);
    chk("rsv_lo", lo, 32'h9ABC_DEF0);

    // divide by zero leaves HI/LO alone
    issue(3'b100, 32'h11, 32'h0);
    issue(3'b101, 32'h22, 32'h0);
    issue(3'b010, 32'd5, 32'd0);
    wait_done("div0", 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // back-to-back: issue in the done cycle, signed overflow divide
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_done("ovf", 10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    tick();

    // reset during a divide
    issue(3'b011, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrun_busy", {31'b0, busy}, 0);
    chk("rstrun_hi", hi, 0);
    chk("rstrun_lo", lo, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
      tick();
    end
    chk("rstrun_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
